// File: rtl/conv_pkg.sv
// Shared sizing constants and owner encoding for the conv SRAM arbiter.
package conv_pkg;

    localparam int ADDR_W    = 17;
    localparam int DATA_W    = 32;
    localparam int MAX_BURST = 16;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_t;

endpackage

// File: rtl/conv_mem_arbiter.sv
// Two-port single-SRAM arbiter: combinational grant with round-robin ties,
// bounded ownership lock, and a one-cycle read-valid pipeline per port.
module conv_mem_arbiter
    import conv_pkg::*;
#(
    parameter int ADDR_W    = conv_pkg::ADDR_W,
    parameter int DATA_W    = conv_pkg::DATA_W,
    parameter int MAX_BURST = conv_pkg::MAX_BURST
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                a_req,
    input  logic                a_lock,
    input  logic [ADDR_W-1:0]   a_addr,
    input  logic [DATA_W/8-1:0] a_web,
    input  logic [DATA_W-1:0]   a_wdata,
    output logic                a_gnt,
    output logic                a_rvalid,

    input  logic                b_req,
    input  logic                b_lock,
    input  logic [ADDR_W-1:0]   b_addr,
    input  logic [DATA_W/8-1:0] b_web,
    input  logic [DATA_W-1:0]   b_wdata,
    output logic                b_gnt,
    output logic                b_rvalid,

    output logic [ADDR_W-1:0]   sram_addr,
    output logic [DATA_W/8-1:0] sram_web,
    output logic [DATA_W-1:0]   sram_wdata,
    output logic                sram_oe,
    input  logic [DATA_W-1:0]   sram_rdata,
    output logic [DATA_W-1:0]   rd_data
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

    owner_t            last_gnt;
    logic              lock_q;
    logic [CNT_W-1:0]  burst_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              a_rvalid_q;
    logic              b_rvalid_q;

    owner_t            win;
    owner_t            gnt_own;
    logic              any_gnt;
    logic              gnt_lock;

    // A live lock keeps the previous owner unless its burst is spent, in which
    // case the tie falls through to round-robin and the waiting port gets in.
    always_comb begin
        win   = (last_gnt == OWN_A) ? OWN_B : OWN_A;
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (lock_q && (burst_cnt != BURST_LAST)) begin
            win = last_gnt;
        end
        if (!rst) begin
            if (a_req && b_req) begin
                a_gnt = (win == OWN_A);
                b_gnt = (win == OWN_B);
            end else begin
                a_gnt = a_req;
                b_gnt = b_req;
            end
        end
    end

    assign any_gnt  = a_gnt | b_gnt;
    assign gnt_own  = b_gnt ? OWN_B : OWN_A;
    assign gnt_lock = b_gnt ? b_lock : a_lock;

    // Idle cycles replay the last address/data so the SRAM pins do not toggle.
    always_comb begin
        sram_addr  = addr_q;
        sram_wdata = wdata_q;
        sram_web   = {BE_W{1'b1}};
        if (rst) begin
            sram_addr  = '0;
            sram_wdata = '0;
        end else if (a_gnt) begin
            sram_addr  = a_addr;
            sram_wdata = a_wdata;
            sram_web   = a_web;
        end else if (b_gnt) begin
            sram_addr  = b_addr;
            sram_wdata = b_wdata;
            sram_web   = b_web;
        end
    end

    assign sram_oe = any_gnt && (&sram_web);
    assign rd_data = sram_rdata;

    // NOTE: rvalid is masked by rst so a read issued just before reset never
    // shows up while reset is held; the register itself clears on that edge.
    assign a_rvalid = a_rvalid_q && !rst;
    assign b_rvalid = b_rvalid_q && !rst;

    // NOTE: all state uses non-blocking assignments so every register samples
    // the same pre-edge grant decision.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt   <= OWN_B;
            lock_q     <= 1'b0;
            burst_cnt  <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
        end else begin
            a_rvalid_q <= a_gnt && (&a_web);
            b_rvalid_q <= b_gnt && (&b_web);
            addr_q     <= sram_addr;
            wdata_q    <= sram_wdata;
            if (any_gnt) begin
                last_gnt <= gnt_own;
                lock_q   <= gnt_lock;
                if (gnt_lock && lock_q && (gnt_own == last_gnt)) begin
                    burst_cnt <= (burst_cnt == BURST_LAST) ? burst_cnt : burst_cnt + 1'b1;
                end else begin
                    burst_cnt <= '0;
                end
            end else begin
                lock_q    <= 1'b0;
                burst_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_conv_mem_arbiter.sv
// Directed bench for conv_mem_arbiter: grant order, lock bursts, rvalid timing,
// reset behaviour and idle bus stability.
module tb_conv_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_req, a_lock, b_req, b_lock;
    logic [16:0] a_addr, b_addr;
    logic [3:0]  a_web, b_web;
    logic [31:0] a_wdata, b_wdata;
    logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [16:0] sram_addr;
    logic [3:0]  sram_web;
    logic [31:0] sram_wdata;
    logic        sram_oe;
    logic [31:0] sram_rdata;
    logic [31:0] rd_data;

    int total = 0;
    int bad   = 0;

    conv_mem_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .a_req      (a_req),
        .a_lock     (a_lock),
        .a_addr     (a_addr),
        .a_web      (a_web),
        .a_wdata    (a_wdata),
        .a_gnt      (a_gnt),
        .a_rvalid   (a_rvalid),
        .b_req      (b_req),
        .b_lock     (b_lock),
        .b_addr     (b_addr),
        .b_web      (b_web),
        .b_wdata    (b_wdata),
        .b_gnt      (b_gnt),
        .b_rvalid   (b_rvalid),
        .sram_addr  (sram_addr),
        .sram_web   (sram_web),
        .sram_wdata (sram_wdata),
        .sram_oe    (sram_oe),
        .sram_rdata (sram_rdata),
        .rd_data    (rd_data)
    );

    always #5 clk = ~clk;

    // Inputs change 1 ns after the rising edge; checks happen at the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic idle_inputs();
        a_req = 0; a_lock = 0; a_addr = '0; a_web = 4'hF; a_wdata = '0;
        b_req = 0; b_lock = 0; b_addr = '0; b_web = 4'hF; b_wdata = '0;
    endtask

    task automatic do_reset();
        rst = 1;
        idle_inputs();
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        idle_inputs();
        a_req = 1; b_req = 1; a_addr = 17'h00ABC; a_wdata = 32'hCAFEF00D; a_web = 4'h0;
        tick();
        tick();
        settle();
        total++;
        if (a_gnt !== 1'b0 || b_gnt !== 1'b0) begin
            bad++; $display("FAIL reset_gnt: got a=%b b=%b want 0 0", a_gnt, b_gnt);
        end
        total++;
        if (sram_web !== 4'hF || sram_oe !== 1'b0) begin
            bad++; $display("FAIL reset_web_oe: got web=%h oe=%b want F 0", sram_web, sram_oe);
        end
        total++;
        if (sram_addr !== 17'h0 || sram_wdata !== 32'h0) begin
            bad++; $display("FAIL reset_bus: got addr=%h wdata=%h want 0 0", sram_addr, sram_wdata);
        end
        total++;
        if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin
            bad++; $display("FAIL reset_rvalid: got a=%b b=%b want 0 0", a_rvalid, b_rvalid);
        end
        tick();
        rst = 0;
        idle_inputs();
    endtask

    task automatic test_round_robin();
        logic exp_a;
        a_req = 1; b_req = 1;
        for (int i = 0; i < 4; i++) begin
            exp_a = (i % 2 == 0);
            settle();
            total++;
            if (a_gnt !== exp_a || b_gnt !== !exp_a) begin
                bad++; $display("FAIL rr_cycle%0d: got a=%b b=%b want a=%b b=%b", i, a_gnt, b_gnt, exp_a, !exp_a);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_read_a();
        a_req = 1; a_addr = 17'h00010; a_web = 4'hF;
        settle();
        total++;
        if (a_gnt !== 1'b1 || sram_addr !== 17'h00010 || sram_oe !== 1'b1) begin
            bad++; $display("FAIL read_issue: got gnt=%b addr=%h oe=%b want 1 00010 1", a_gnt, sram_addr, sram_oe);
        end
        tick();
        idle_inputs();
        sram_rdata = 32'hDEADBEEF;
        settle();
        total++;
        if (a_rvalid !== 1'b1 || b_rvalid !== 1'b0 || rd_data !== 32'hDEADBEEF) begin
            bad++; $display("FAIL read_return: got a_rv=%b b_rv=%b data=%h want 1 0 deadbeef", a_rvalid, b_rvalid, rd_data);
        end
        tick();
        settle();
        total++;
        if (a_rvalid !== 1'b0) begin
            bad++; $display("FAIL read_single_rvalid: got %b want 0", a_rvalid);
        end
        tick();
    endtask

    // Last grant was A, so alternation starts with B.
    task automatic test_back_to_back();
        logic exp_ag, exp_arv, exp_brv;
        a_req = 1; b_req = 1; a_addr = 17'h00100; b_addr = 17'h00200;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin a_req = 0; b_req = 0; end
            exp_ag  = (i % 2 == 1);
            exp_arv = (i >= 2) && (i % 2 == 0);
            exp_brv = (i >= 1) && (i % 2 == 1);
            settle();
            if (i < 4) begin
                total++;
                if (a_gnt !== exp_ag || b_gnt !== !exp_ag) begin
                    bad++; $display("FAIL b2b_gnt%0d: got a=%b b=%b want a=%b", i, a_gnt, b_gnt, exp_ag);
                end
            end
            total++;
            if (a_rvalid !== exp_arv || b_rvalid !== exp_brv) begin
                bad++; $display("FAIL b2b_rvalid%0d: got a=%b b=%b want a=%b b=%b", i, a_rvalid, b_rvalid, exp_arv, exp_brv);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_write_b();
        b_req = 1; b_web = 4'h3; b_wdata = 32'h12345678; b_addr = 17'h1FFFF;
        settle();
        total++;
        if (b_gnt !== 1'b1 || a_gnt !== 1'b0) begin
            bad++; $display("FAIL write_gnt: got a=%b b=%b want 0 1", a_gnt, b_gnt);
        end
        total++;
        if (sram_web !== 4'h3 || sram_addr !== 17'h1FFFF || sram_wdata !== 32'h12345678 || sram_oe !== 1'b0) begin
            bad++; $display("FAIL write_bus: got web=%h addr=%h wdata=%h oe=%b want 3 1ffff 12345678 0",
                            sram_web, sram_addr, sram_wdata, sram_oe);
        end
        tick();
        idle_inputs();
        settle();
        total++;
        if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin
            bad++; $display("FAIL write_no_rvalid: got a=%b b=%b want 0 0", a_rvalid, b_rvalid);
        end
        tick();
    endtask

    task automatic test_lock_release();
        do_reset();
        a_req = 1; b_req = 1; a_lock = 1;
        for (int i = 0; i < 2; i++) begin
            settle();
            total++;
            if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
                bad++; $display("FAIL lockrel_hold%0d: got a=%b b=%b want 1 0", i, a_gnt, b_gnt);
            end
            tick();
        end
        a_req = 0;
        settle();
        total++;
        if (a_gnt !== 1'b0 || b_gnt !== 1'b1) begin
            bad++; $display("FAIL lockrel_drop: got a=%b b=%b want 0 1", a_gnt, b_gnt);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_lock_burst();
        do_reset();
        a_req = 1; b_req = 1; a_lock = 1;
        for (int i = 1; i <= 16; i++) begin
            settle();
            total++;
            if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
                bad++; $display("FAIL burst_a_cycle%0d: got a=%b b=%b want 1 0", i, a_gnt, b_gnt);
            end
            tick();
        end
        settle();
        total++;
        if (a_gnt !== 1'b0 || b_gnt !== 1'b1) begin
            bad++; $display("FAIL burst_handoff_cycle17: got a=%b b=%b want 0 1", a_gnt, b_gnt);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_reset_after_read();
        do_reset();
        a_req = 1; a_addr = 17'h00020; a_web = 4'hF;
        settle();
        total++;
        if (a_gnt !== 1'b1) begin
            bad++; $display("FAIL rar_issue: got gnt=%b want 1", a_gnt);
        end
        tick();
        idle_inputs();
        rst = 1;
        settle();
        total++;
        if (a_rvalid !== 1'b0) begin
            bad++; $display("FAIL rar_in_reset: got a_rvalid=%b want 0", a_rvalid);
        end
        tick();
        rst = 0;
        settle();
        total++;
        if (a_rvalid !== 1'b0) begin
            bad++; $display("FAIL rar_after_reset: got a_rvalid=%b want 0", a_rvalid);
        end
        tick();
        a_req = 1; b_req = 1; a_addr = 17'h00123; b_addr = 17'h00456;
        settle();
        total++;
        if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
            bad++; $display("FAIL rar_first_tie: got a=%b b=%b want 1 0", a_gnt, b_gnt);
        end
        tick();
        idle_inputs();
    endtask

    // Follows test_reset_after_read, whose last access drove address 0x00123.
    task automatic test_idle();
        for (int i = 0; i < 5; i++) begin
            settle();
            total++;
            if (sram_web !== 4'hF || sram_oe !== 1'b0 || a_gnt !== 1'b0 || b_gnt !== 1'b0) begin
                bad++; $display("FAIL idle%0d_ctrl: got web=%h oe=%b gnt=%b%b want F 0 00", i, sram_web, sram_oe, a_gnt, b_gnt);
            end
            total++;
            if (sram_addr !== 17'h00123) begin
                bad++; $display("FAIL idle%0d_addr: got %h want 00123", i, sram_addr);
            end
            total++;
            if (dut.burst_cnt !== '0) begin
                bad++; $display("FAIL idle%0d_burst: got %0d want 0", i, dut.burst_cnt);
            end
            tick();
        end
    endtask

    initial begin
        sram_rdata = 32'h0;
        test_reset();
        test_round_robin();
        test_read_a();
        test_back_to_back();
        test_write_b();
        test_lock_release();
        test_lock_burst();
        test_reset_after_read();
        test_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, want finish before 100000ns");
        $fatal(1);
    end

endmodule
